// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences push/pop/call/ret on a downward-growing memory stack.
// Shares the single data-memory port with the MEM-stage load/store path,
// which always wins. Stalls ID while a pop/ret read is outstanding.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   push_req/pop_req/
//   call_req/ret_req          stack requests, priority ret > pop > call > push
//   push_data, call_ret_addr  write values for push / call
//   lsu_req/we/addr/wdata     load/store request for the memory port
//   mem_en/we/addr/wdata      memory port (combinational mux)
//   mem_rdata                 synchronous-read data, valid the cycle after a read
//   stall                     hold the ID stage
//   pop_data/pop_valid        popped value and its one-cycle pulse
//   ret_pc/ret_valid          popped return address and its one-cycle pulse
//   sp                        next free slot address
//   overflow/underflow        sticky error flags, cleared only by rst
module stack_ctrl #(
  parameter int unsigned         DATA_W    = 19,
  parameter logic [DATA_W-1:0]   STACK_TOP = DATA_W'(19'h7FFFF),
  parameter int unsigned         DEPTH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] call_ret_addr,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [DATA_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] ret_pc,
  output logic              ret_valid,
  output logic [DATA_W-1:0] sp,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              op_ret;

  logic any_req, sel_rd, sel_wr, sel_call;
  logic is_full, is_empty, stack_go;
  logic do_write, do_read, ovf_hit, unf_hit;
  logic [DATA_W-1:0] wr_val;

  // Request decode with fixed priority ret > pop > call > push.
  assign any_req  = push_req | pop_req | call_req | ret_req;
  assign sel_rd   = ret_req | pop_req;
  assign sel_wr   = ~sel_rd & (call_req | push_req);
  assign sel_call = ~sel_rd & call_req;
  assign wr_val   = sel_call ? call_ret_addr : push_data;

  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);

  // Stack may act only in IDLE with the port free; gated by rst so nothing
  // reaches memory while reset is held.
  assign stack_go = ~rst & (state == IDLE) & ~lsu_req;
  assign do_write = stack_go & sel_wr & ~is_full;
  assign do_read  = stack_go & sel_rd & ~is_empty;
  assign ovf_hit  = stack_go & sel_wr & is_full;
  assign unf_hit  = stack_go & sel_rd & is_empty;

  // Memory port mux: LSU pass-through unless the stack issues an access.
  always_comb begin
    mem_en    = lsu_req;
    mem_we    = lsu_req & lsu_we;
    mem_addr  = lsu_addr;
    mem_wdata = lsu_wdata;
    if (do_write) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = sp;
      mem_wdata = wr_val;
    end else if (do_read) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = sp + DATA_W'(1);
    end
  end

  // Hold ID while the LSU blocks a stack op, or while a read is outstanding.
  assign stall = (state == IDLE) & ((lsu_req & any_req) | do_read);

  // Stack state, sequencing and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= STACK_TOP;
      count     <= '0;
      op_ret    <= 1'b0;
      pop_data  <= '0;
      ret_pc    <= '0;
      pop_valid <= 1'b0;
      ret_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      ret_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (do_write) begin
            sp    <= sp - DATA_W'(1);
            count <= count + CNT_W'(1);
          end
          if (ovf_hit) overflow <= 1'b1;
          if (unf_hit) underflow <= 1'b1;
          if (do_read) begin
            sp     <= sp + DATA_W'(1);
            count  <= count - CNT_W'(1);
            op_ret <= ret_req;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Read data arrives this cycle; held requests are ignored.
          if (op_ret) begin
            ret_pc    <= mem_rdata;
            ret_valid <= 1'b1;
          end else begin
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: directed plan steps plus randomized operations,
// checked against a queue-based stack model and a behavioural memory.
module tb_stack_ctrl;

  localparam int unsigned DW    = 19;
  localparam logic [18:0] TOP   = 19'h7FFFF;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic push_req, pop_req, call_req, ret_req;
  logic [DW-1:0] push_data, call_ret_addr;
  logic lsu_req, lsu_we;
  logic [DW-1:0] lsu_addr, lsu_wdata;
  logic mem_en, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic stall, pop_valid, ret_valid, overflow, underflow;
  logic [DW-1:0] pop_data, ret_pc, sp;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] stk[$];
  bit exp_ovf, exp_unf;

  logic [DW-1:0] mem_m [logic [DW-1:0]];

  stack_ctrl #(.DATA_W(DW), .STACK_TOP(TOP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_req(push_req), .pop_req(pop_req), .call_req(call_req), .ret_req(ret_req),
    .push_data(push_data), .call_ret_addr(call_ret_addr),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall),
    .pop_data(pop_data), .pop_valid(pop_valid), .ret_pc(ret_pc), .ret_valid(ret_valid),
    .sp(sp), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory behind the port.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_m[mem_addr] = mem_wdata;
      else mem_rdata <= mem_m.exists(mem_addr) ? mem_m[mem_addr] : '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    push_req = 0; pop_req = 0; call_req = 0; ret_req = 0;
  endtask

  task automatic drive_lsu(input logic [DW-1:0] a, input logic w);
    lsu_req   = 1'b1;
    lsu_we    = w;
    lsu_addr  = a;
    lsu_wdata = DW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    push_req = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_sp", sp, TOP);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_ret_pc", ret_pc, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(posedge clk); #1;
    push_req = 1'b0;
    rst = 1'b0;
    stk.delete();
    exp_ovf = 0; exp_unf = 0;
  endtask

  // One stack instruction: reqs = {ret,pop,call,push}; LSU holds the port for
  // lsu_cyc cycles first; lsu_wait also uses the port during the read wait.
  task automatic op(input logic [3:0] reqs, input logic [DW-1:0] pd,
                    input logic [DW-1:0] ca, input int lsu_cyc, input bit lsu_wait);
    logic [DW-1:0] exp_sp, val;
    bit is_ret;
    push_req = reqs[0]; call_req = reqs[1]; pop_req = reqs[2]; ret_req = reqs[3];
    push_data = pd; call_ret_addr = ca;
    for (int i = 0; i < lsu_cyc; i++) begin
      drive_lsu(DW'($urandom_range(0, 19'h0FFF)), 1'($urandom));
      @(negedge clk);
      chk("lsu_stall", stall, reqs != 0);
      chk("lsu_en", mem_en, 1);
      chk("lsu_we", mem_we, lsu_we);
      chk("lsu_addr", mem_addr, lsu_addr);
      chk("lsu_wdata", mem_wdata, lsu_wdata);
      @(posedge clk); #1;
    end
    lsu_req = 1'b0;
    exp_sp = TOP - DW'(stk.size());
    is_ret = reqs[3];
    @(negedge clk);
    if (reqs[3] | reqs[2]) begin
      if (stk.size() > 0) begin
        chk("rd_en", mem_en, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, exp_sp + DW'(1));
        chk("rd_stall", stall, 1);
        @(posedge clk); #1;
        val = stk.pop_back();
        if (lsu_wait) drive_lsu(DW'($urandom_range(0, 19'h0FFF)), 1'($urandom));
        @(negedge clk);
        chk("wait_stall", stall, 0);
        if (lsu_wait) begin
          chk("wait_lsu_en", mem_en, 1);
          chk("wait_lsu_addr", mem_addr, lsu_addr);
        end
        @(posedge clk); #1;
        clear_reqs(); lsu_req = 1'b0;
        @(negedge clk);
        chk("pop_valid", pop_valid, !is_ret);
        chk("ret_valid", ret_valid, is_ret);
        if (is_ret) chk("ret_pc", ret_pc, val);
        else chk("pop_data", pop_data, val);
        @(posedge clk); #1;
        @(negedge clk);
      end else begin
        chk("unf_stall", stall, 0);
        chk("unf_en", mem_en, 0);
        exp_unf = 1;
        @(posedge clk); #1;
        clear_reqs();
        @(negedge clk);
      end
    end else if (reqs[1] | reqs[0]) begin
      val = reqs[1] ? ca : pd;
      if (stk.size() < DEPTH) begin
        chk("wr_en", mem_en, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, exp_sp);
        chk("wr_data", mem_wdata, val);
        chk("wr_stall", stall, 0);
        stk.push_back(val);
      end else begin
        chk("ovf_en", mem_en, 0);
        chk("ovf_stall", stall, 0);
        exp_ovf = 1;
      end
      @(posedge clk); #1;
      clear_reqs();
      @(negedge clk);
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("sp", sp, TOP - DW'(stk.size()));
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_unf);
    chk("idle_pop_valid", pop_valid, 0);
    chk("idle_ret_valid", ret_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] r;
    int k;
    rst = 1'b1;
    clear_reqs();
    push_data = '0; call_ret_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0;

    // Single push after reset.
    do_reset();
    op(4'b0001, 19'h00ABC, '0, 0, 0);

    // LIFO order on two pops.
    do_reset();
    op(4'b0001, 19'h00001, '0, 0, 0);
    op(4'b0001, 19'h00002, '0, 0, 0);
    op(4'b0100, '0, '0, 0, 0);
    op(4'b0100, '0, '0, 0, 0);

    // Call then return.
    op(4'b0010, '0, 19'h01234, 0, 0);
    op(4'b1000, '0, '0, 0, 0);

    // Push blocked by the LSU for two cycles, pop with LSU in the wait cycle.
    op(4'b0001, 19'h00077, '0, 2, 0);
    op(4'b0100, '0, '0, 1, 1);

    // Priority with simultaneous requests.
    op(4'b0001, 19'h00011, '0, 0, 0);
    op(4'b0011, 19'h00022, 19'h00033, 0, 0);
    op(4'b0111, 19'h00044, 19'h00055, 0, 0);
    op(4'b1111, 19'h00066, 19'h00088, 0, 0);

    // Fill past full, then drain past empty.
    do_reset();
    for (int i = 0; i < 17; i++) op(4'b0001, DW'(i + 100), '0, 0, 0);
    for (int i = 0; i < 17; i++) op(4'b0100, '0, '0, 0, 0);

    // Reset while the pop read is outstanding.
    do_reset();
    op(4'b0001, 19'h00055, '0, 0, 0);
    pop_req = 1'b1;
    @(negedge clk);
    chk("abort_stall1", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    pop_req = 1'b0;
    @(negedge clk);
    chk("abort_pop_valid", pop_valid, 0);
    chk("abort_sp", sp, TOP);
    chk("abort_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_pop_valid2", pop_valid, 0);
    @(posedge clk); #1;
    stk.delete(); exp_ovf = 0; exp_unf = 0;
    op(4'b0100, '0, '0, 0, 0);

    // Randomized operations, push-biased then pop-biased.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 99));
      if (k < 10) r = 4'($urandom_range(1, 15));
      else if (k < ((n % 100) < 50 ? 60 : 30)) r = $urandom_range(0, 1) ? 4'b0001 : 4'b0010;
      else if (k < 95) r = $urandom_range(0, 1) ? 4'b0100 : 4'b1000;
      else r = 4'b0000;
      op(r, DW'($urandom), DW'($urandom),
         ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
         1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer for the stack operations decoded by the control unit: push, pop, call (jump-and-link) and ret.
- Owns the stack pointer and occupancy count.
- Shares the single data-memory port with the MEM-stage load/store path; the load/store path always has priority.
- Stalls the ID stage until each stack operation completes, and returns popped data or the return PC to the pipeline.

Parameters:
- DATA_W, 19, width of data words, addresses and PC.
- STACK_TOP, 19'h7FFFF, address of the first (highest) stack slot; the stack grows downward.
- DEPTH, 16, maximum number of stack entries; 2..2^16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- push_req  in  1  push push_data (held while stall=1)
- pop_req  in  1  pop into pop_data
- call_req  in  1  push call_ret_addr
- ret_req  in  1  pop into ret_pc
- push_data  in  DATA_W  data for push
- call_ret_addr  in  DATA_W  return address (PC+1) for call
- lsu_req  in  1  MEM-stage load/store wants the memory port
- lsu_we  in  1  load/store write enable
- lsu_addr  in  DATA_W  load/store address
- lsu_wdata  in  DATA_W  load/store write data
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after a read is issued
- stall  out  1  hold the ID stage
- pop_data  out  DATA_W  popped value
- pop_valid  out  1  one-cycle pulse, pop_data valid
- ret_pc  out  DATA_W  popped return address
- ret_valid  out  1  one-cycle pulse, ret_pc valid (PC redirect)
- sp  out  DATA_W  next free slot address
- overflow  out  1  sticky: push/call attempted while full
- underflow  out  1  sticky: pop/ret attempted while empty

Behaviour:
- Reset (async):
  - sp=STACK_TOP, count=0, state=IDLE.
  - pop_data=0, ret_pc=0, pop_valid=0, ret_valid=0, overflow=0, underflow=0.
  - Memory outputs are driven to the LSU pass-through values (mem_en=lsu_req), so no stack access is issued.
- Stack request selection: a stack request is any of push_req, pop_req, call_req, ret_req. If more than one is high, the fixed priority ret > pop > call > push applies; the lower-priority requests are ignored for that operation.
- The memory port mux is combinational from state and inputs. When lsu_req=1, the port carries the LSU fields unchanged, in any state.
- State IDLE:
  - lsu_req=1: the LSU owns the port. stall = any stack request. No stack state changes.
  - Push or call, count<DEPTH:
    - mem_en=1, mem_we=1, mem_addr=sp, mem_wdata=push_data or call_ret_addr.
    - sp<=sp-1, count<=count+1, stall=0; the operation completes in 1 cycle.
  - Push or call, count==DEPTH:
    - No write, overflow<=1, stall=0 (the instruction is dropped).
  - Pop or ret, count>0:
    - mem_en=1, mem_we=0, mem_addr=sp+1.
    - sp<=sp+1, count<=count-1, latch the op type, stall=1, go to RD_WAIT.
  - Pop or ret, count==0:
    - underflow<=1, stall=0, no memory access.
    - A ret with an empty stack does not assert ret_valid.
- State RD_WAIT (always lasts exactly 1 cycle):
  - Capture mem_rdata into pop_data (pop) or ret_pc (ret), then pulse pop_valid or ret_valid for 1 cycle, aligned with the registered value.
  - stall=0.
  - The stack port is unused, so lsu_req is serviced normally.
  - Stack requests present in this cycle are ignored; they are the completing instruction's held request.
  - Next state: IDLE.
- Latency from the first cycle the port is free:
  - push/call: 1 cycle, stall=0.
  - pop/ret: 2 cycles, stall=1 then 0.
  - pop_valid/ret_valid rise in the cycle after RD_WAIT (registered).
- sp arithmetic is modulo 2^DATA_W; count is clog2(DEPTH+1) bits wide. Full means count==DEPTH, empty means count==0; sp wrap cannot occur within the legal range.
- overflow and underflow clear only on rst.
- A reset in RD_WAIT aborts the pop: no valid pulse is produced, and sp and count return to their reset values.

Test Plan:
- Reset, then push 19'h00ABC → mem_we=1, mem_addr=19'h7FFFF, mem_wdata=19'h00ABC, stall=0; sp becomes 19'h7FFFE, count=1.
- Push 19'h00001, then 19'h00002; pop twice → reads at 19'h7FFFE then 19'h7FFFF. pop_data=19'h00002 then 19'h00001, each with one pop_valid pulse. stall pattern per pop is 1,0; sp ends at 19'h7FFFF.
- call_req with call_ret_addr=19'h01234, then ret_req → write to 19'h7FFFF; ret_pc=19'h01234 with a single ret_valid pulse.
- push_req together with lsu_req=1 (lsu_we=1, lsu_addr=19'h00010) for 2 cycles → the port carries the LSU write and stall=1 for those 2 cycles. The push completes in the 3rd cycle, when lsu_req=0.
- 16 pushes, then a 17th → the 17th issues no write, overflow=1, sp=19'h7FFEF. Then 17 pops → the 17th issues no read, underflow=1, no pop_valid.
- Assert rst during RD_WAIT → pop_valid stays 0, sp=19'h7FFFF, count=0, stall=0.
